// File: rtl/event_reporter_pkg.sv
// event_reporter_pkg: shared message layout constants and FSM state type for event_reporter_mc
package event_reporter_pkg;
   localparam logic [7:0] MSG_TYPE_EVENT = 8'h01;
   localparam int CODE_LSB  = 0;
   localparam int COUNT_LSB = 16;
   localparam int TS_LSB    = 48;
   localparam int TS_WIDTH  = 32;
   typedef enum logic {IDLE, SEND} state_e;
   function automatic int type_msb(input int data_width);
      return data_width - 1;
   endfunction
endpackage

// File: rtl/event_reporter_mc_if.sv
// event_reporter_mc_if: AXI-Stream report channel (tdata/tvalid from master, tready from slave)
interface event_reporter_mc_if #(parameter int DATA_WIDTH = 256);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   modport master(output tdata, tvalid, input tready);
   modport slave(input tdata, tvalid, output tready);
endinterface

// File: rtl/event_reporter_mc_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; req_i/last_grant_i in, grant_o/any_o out
module rr_arbiter #(
   parameter int N  = 8,
   parameter int GW = N > 1 ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [GW-1:0] last_grant_i,
   output logic [GW-1:0] grant_o,
   output logic          any_o
);
   // Scan from the farthest candidate down to the nearest so the last hit wins,
   // giving priority to (last_grant+1) mod N.
   always_comb begin
      grant_o = '0;
      for (int k = N; k >= 1; k--)
         if (req_i[(int'(last_grant_i) + k) % N]) grant_o = GW'((int'(last_grant_i) + k) % N);
      any_o = |req_i;
   end
endmodule

// File: rtl/event_reporter_mc.sv
// event_reporter_mc: coalesces per-channel event strobes (count + first timestamp) into AXI-Stream reports
// Ports: clk, reset (sync, active-high); event_strobe/event_enable per channel;
//        axis_out (master: tdata, tvalid, tready); overrun sticky per-channel saturation flags.
module event_reporter_mc
   import event_reporter_pkg::*;
#(
   parameter int DATA_WIDTH  = 256,
   parameter int NUM_EVENTS  = 8,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_EVENTS-1:0] event_strobe,
   input  logic [NUM_EVENTS-1:0] event_enable,
   event_reporter_mc_if.master   axis_out,
   output logic [NUM_EVENTS-1:0] overrun
);
   localparam int GW = NUM_EVENTS > 1 ? $clog2(NUM_EVENTS) : 1;
   localparam logic [COUNT_WIDTH-1:0] CMAX = '1;
   state_e                  state_q, state_d;
   logic [NUM_EVENTS-1:0]   pending_q, pending_d, overrun_q, overrun_d;
   logic [COUNT_WIDTH-1:0]  count_q [NUM_EVENTS];
   logic [COUNT_WIDTH-1:0]  count_d [NUM_EVENTS];
   logic [TS_WIDTH-1:0]     first_ts_q [NUM_EVENTS];
   logic [TS_WIDTH-1:0]     first_ts_d [NUM_EVENTS];
   logic [TS_WIDTH-1:0]     ts_q;
   logic [GW-1:0]           last_grant_q, grant;
   logic                    any_req, load, tvalid_q, tvalid_d;
   logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;

   rr_arbiter #(.N(NUM_EVENTS), .GW(GW)) u_arb (
      .req_i(pending_q), .last_grant_i(last_grant_q), .grant_o(grant), .any_o(any_req)
   );

   always_comb begin
      state_d  = state_q;
      tvalid_d = tvalid_q;
      tdata_d  = tdata_q;
      load     = 1'b0;
      if (state_q == IDLE) begin
         load = any_req;
         if (any_req) begin
            state_d  = SEND;
            tvalid_d = 1'b1;
            tdata_d  = '0;
            tdata_d[type_msb(DATA_WIDTH) -: 8]   = MSG_TYPE_EVENT;
            tdata_d[CODE_LSB +: 8]               = 8'(grant) + 8'd1;
            tdata_d[COUNT_LSB +: COUNT_WIDTH]    = count_q[grant];
            tdata_d[TS_LSB +: TS_WIDTH]          = first_ts_q[grant];
         end
      end else if (axis_out.tready) begin
         state_d  = IDLE;
         tvalid_d = 1'b0;
      end
   end

   // The granted channel is cleared first, so a strobe on the load edge
   // restarts it as a fresh occurrence instead of being lost.
   always_comb begin
      overrun_d = overrun_q;
      for (int i = 0; i < NUM_EVENTS; i++) begin
         pending_d[i]  = pending_q[i];
         count_d[i]    = count_q[i];
         first_ts_d[i] = first_ts_q[i];
         if (!event_enable[i]) begin
            pending_d[i]  = 1'b0;
            count_d[i]    = '0;
            first_ts_d[i] = '0;
         end else begin
            if (load && grant == GW'(i)) begin
               pending_d[i]  = 1'b0;
               count_d[i]    = '0;
               first_ts_d[i] = '0;
            end
            if (event_strobe[i]) begin
               if (!pending_d[i]) begin
                  pending_d[i]  = 1'b1;
                  count_d[i]    = COUNT_WIDTH'(1);
                  first_ts_d[i] = ts_q;
               end else if (count_d[i] != CMAX) count_d[i] = count_d[i] + 1'b1;
               overrun_d[i] = overrun_q[i] | (count_d[i] == CMAX);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         pending_q    <= '0;
         overrun_q    <= '0;
         count_q      <= '{default: '0};
         first_ts_q   <= '{default: '0};
         ts_q         <= '0;
         last_grant_q <= GW'(NUM_EVENTS - 1);
         tvalid_q     <= 1'b0;
         tdata_q      <= '0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         overrun_q  <= overrun_d;
         count_q    <= count_d;
         first_ts_q <= first_ts_d;
         ts_q       <= ts_q + 1'b1;
         tvalid_q   <= tvalid_d;
         tdata_q    <= tdata_d;
         if (load) last_grant_q <= grant;
      end
   end

   assign axis_out.tdata  = tdata_q;
   assign axis_out.tvalid = tvalid_q;
   assign overrun         = overrun_q;
endmodule

// File: tb/tb_event_reporter_mc.sv
// tb_event_reporter_mc: scoreboard bench for event_reporter_mc (COUNT_WIDTH=4, 8 channels)
module tb_event_reporter_mc;
   logic         clk = 1'b0;
   logic         reset;
   logic [7:0]   event_strobe, event_enable, overrun;
   logic [31:0]  tb_ts;
   logic [255:0] q[$];
   int           vectors = 0, miscompares = 0;

   event_reporter_mc_if #(.DATA_WIDTH(256)) axis ();

   event_reporter_mc #(.DATA_WIDTH(256), .NUM_EVENTS(8), .COUNT_WIDTH(4)) dut (
      .clk(clk), .reset(reset), .event_strobe(event_strobe), .event_enable(event_enable),
      .axis_out(axis), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Cycle reference: the value a strobe driven now will be stamped with.
   always @(posedge clk) tb_ts <= reset ? 32'd0 : tb_ts + 32'd1;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] msg(input int ch, input int cnt, input logic [31:0] t);
      logic [255:0] m;
      m = '0;
      m[255:248] = 8'h01;
      m[7:0]     = 8'(ch + 1);
      m[47:16]   = 32'(cnt);
      m[79:48]   = t;
      return m;
   endfunction

   // A beat with nothing expected compares against zero and so always miscompares.
   always @(negedge clk) begin
      logic [255:0] e;
      if (!reset && axis.tvalid && axis.tready) begin
         e = q.size() > 0 ? q.pop_front() : '0;
         chk("beat", axis.tdata, e);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [7:0] m);
      event_strobe = m;
      tick();
      event_strobe = '0;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && q.size() > 0; i++) tick();
      chk("drain", 256'(q.size()), 256'd0);
      repeat (5) tick();
   endtask

   initial begin
      logic [31:0] t;
      reset = 1'b1;
      event_strobe = '0;
      event_enable = '1;
      axis.tready = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      chk("rst_tvalid", 256'(axis.tvalid), 256'd0);
      chk("rst_tdata", axis.tdata, 256'd0);
      chk("rst_overrun", 256'(overrun), 256'd0);

      axis.tready = 1'b1;
      for (int i = 0; i < 20 && tb_ts < 10; i++) tick();
      chk("ts_reach10", 256'(tb_ts), 256'd10);
      q.push_back(msg(3, 1, 32'd10));
      strobe(8'h08);
      drain();

      axis.tready = 1'b0;
      t = tb_ts;
      q.push_back(msg(0, 1, t));
      q.push_back(msg(0, 4, t + 1));
      for (int k = 0; k < 5; k++) strobe(8'h01);
      repeat (3) tick();
      axis.tready = 1'b1;
      drain();

      t = tb_ts;
      q.push_back(msg(1, 1, t));
      q.push_back(msg(2, 1, t));
      q.push_back(msg(5, 1, t));
      strobe(8'b0010_0110);
      drain();
      t = tb_ts;
      q.push_back(msg(1, 1, t));
      q.push_back(msg(5, 1, t));
      strobe(8'b0010_0010);
      drain();

      axis.tready = 1'b0;
      t = tb_ts;
      q.push_back(msg(7, 1, t));
      q.push_back(msg(7, 15, t + 1));
      for (int k = 0; k < 20; k++) strobe(8'h80);
      chk("overrun_set", 256'(overrun), 256'h80);
      axis.tready = 1'b1;
      drain();
      chk("overrun_sticky", 256'(overrun), 256'h80);

      event_enable = 8'hEF;
      strobe(8'h10);
      repeat (10) tick();
      event_enable = 8'hFF;
      t = tb_ts;
      q.push_back(msg(2, 1, t));
      q.push_back(msg(2, 1, t + 1));
      strobe(8'h04);
      strobe(8'h04);
      drain();

      axis.tready = 1'b0;
      strobe(8'h02);
      for (int i = 0; i < 20 && !axis.tvalid; i++) tick();
      chk("send_tvalid", 256'(axis.tvalid), 256'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_tvalid", 256'(axis.tvalid), 256'd0);
      chk("mid_rst_overrun", 256'(overrun), 256'd0);
      axis.tready = 1'b1;
      repeat (20) tick();
      chk("final_queue", 256'(q.size()), 256'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
